adder_32bit: RTL and testbench

- 32-bit binary adder with carry-in and carry-out.
- Core is a recursive-doubling (Kogge-Stone style) parallel-prefix carry network.
- The result is captured in an output register.
- Used as the final carry-propagate adder stage of the multiplier datapath, and as a general-purpose fast adder.

---
 rtl/adder_32bit.sv | 97 +++++++++
 tb/tb_adder_32bit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/adder_32bit.sv
// adder_32bit: 32-bit registered adder with carry-in/carry-out.
// The carry network is a Kogge-Stone parallel prefix with 5 levels
// (distances 1, 2, 4, 8, 16). cin is merged into the generate of bit 0,
// so after the last level every position i holds the generate of bits i..0
// including cin. Result is registered; synchronous active-high reset.
// Optional macro ADDER32_OVF_EN adds a registered signed-overflow output ovf.
module adder_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
`ifdef ADDER32_OVF_EN
  output logic        ovf,
`endif
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] gen_bit;
  logic [31:0] prop_bit;
  logic [31:0] gen_seed;
  logic [31:0] gen_pfx;
  logic [31:0] carry;
  logic [31:0] sum_d, sum_q;
  logic        cout_d, cout_q;

  assign gen_bit  = a & b;
  assign prop_bit = a ^ b;

  // Bit 0 absorbs cin: it generates if it generates itself or propagates cin.
  assign gen_seed = {gen_bit[31:1], gen_bit[0] | (prop_bit[0] & cin)};

  // Prefix levels. Each level combines position i with position i-d.
  // Positions below d have no partner: the zero-filled shift leaves G intact,
  // and the low-bit mask keeps P intact.
  for (genvar k = 0; k < 5; k++) begin : g_level
    localparam int unsigned Dist = 1 << k;
    localparam logic [31:0] LowMask = ~(32'hFFFF_FFFF << Dist);
    logic [31:0] g_in;
    logic [31:0] p_in;
    logic [31:0] g_out;

    if (k == 0) begin : g_first
      assign g_in = gen_seed;
      assign p_in = prop_bit;
    end else begin : g_next
      assign g_in = g_level[k-1].g_out;
      assign p_in = g_level[k-1].g_pass.p_out;
    end

    assign g_out = g_in | (p_in & (g_in << Dist));

    // The final level's group propagate is never consumed, so it is not built.
    if (k < 4) begin : g_pass
      logic [31:0] p_out;
      assign p_out = p_in & ((p_in << Dist) | LowMask);
    end
  end

  assign gen_pfx = g_level[4].g_out;

  // c_i is the group generate of bits i-1..0 with cin; c_0 is cin itself.
  assign carry  = {gen_pfx[30:0], cin};
  assign sum_d  = prop_bit ^ carry;
  assign cout_d = gen_pfx[31];

`ifdef ADDER32_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_d = carry[31] ^ cout_d;

  // Overflow flag register, cleared by reset alongside the sum.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  // Result register; reset discards whatever operands are present.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 32'd0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_adder_32bit.sv
// Testbench for adder_32bit: directed vectors with explicit expected values,
// then 1000 back-to-back random vectors checked against a 33-bit reference,
// with a single-cycle reset injected mid-stream.
module tb_adder_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
`ifdef ADDER32_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  // Scoreboard entries: {ovf, cout, sum}
  logic [33:0] exp_q[$];

  adder_32bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef ADDER32_OVF_EN
    .ovf  (ovf),
`endif
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] ref_model(input logic r, input logic [31:0] ra,
                                            input logic [31:0] rb, input logic rc);
    logic [32:0] full;
    logic        sov;
    if (r) return 34'd0;
    full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
    sov  = (ra[31] == rb[31]) && (full[31] != ra[31]);
    return {sov, full};
  endfunction

  task automatic check_out(input string tag);
    logic [33:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: no expected entry in scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      assert ({cout, sum} === e[32:0]) else begin
        errors++;
        $error("FAIL %s: observed cout=%b sum=%h expected cout=%b sum=%h",
               tag, cout, sum, e[32], e[31:0]);
      end
`ifdef ADDER32_OVF_EN
      checks++;
      assert (ovf === e[33]) else begin
        errors++;
        $error("FAIL %s ovf: observed %b expected %b", tag, ovf, e[33]);
      end
`endif
    end
  endtask

  // Apply one vector, record its expected result, check one edge later.
  task automatic step_exp(input string tag, input logic r, input logic [31:0] ta,
                          input logic [31:0] tb_, input logic tc,
                          input logic [31:0] exp_sum, input logic exp_cout);
    logic [33:0] m;
    rst = r; a = ta; b = tb_; cin = tc;
    m = ref_model(r, ta, tb_, tc);
    exp_q.push_back({m[33], exp_cout, exp_sum});
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic step_ref(input string tag, input logic r, input logic [31:0] ta,
                          input logic [31:0] tb_, input logic tc);
    rst = r; a = ta; b = tb_; cin = tc;
    exp_q.push_back(ref_model(r, ta, tb_, tc));
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1; a = 32'd0; b = 32'd0; cin = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with operands present
    step_exp("reset0", 1'b1, 32'd123, 32'd456, 1'b0, 32'd0, 1'b0);
    step_exp("reset1", 1'b1, 32'd123, 32'd456, 1'b0, 32'd0, 1'b0);
    step_exp("post_reset", 1'b0, 32'd123, 32'd456, 1'b0, 32'd579, 1'b0);

    // Basic sequence
    step_exp("basic0", 1'b0, 32'd10,   32'd10,   1'b0, 32'd20,   1'b0);
    step_exp("basic1", 1'b0, 32'd200,  32'd10,   1'b0, 32'd210,  1'b0);
    step_exp("basic2", 1'b0, 32'd200,  32'd750,  1'b1, 32'd951,  1'b0);
    step_exp("basic3", 1'b0, 32'd1234, 32'd750,  1'b1, 32'd1985, 1'b0);
    step_exp("basic4", 1'b0, 32'd1234, 32'd5678, 1'b0, 32'd6912, 1'b0);

    // Boundaries
    step_exp("wrap",      1'b0, 32'hFFFF_FFFF, 32'd55, 1'b0, 32'd54, 1'b1);
    step_exp("prop_full", 1'b0, 32'hFFFF_FFFF, 32'd0,  1'b1, 32'd0,  1'b1);
    step_exp("prop_31",   1'b0, 32'h7FFF_FFFF, 32'd0,  1'b1, 32'h8000_0000, 1'b0);
    step_exp("max_max",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step_exp("zero",      1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    step_exp("alt_bits",  1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'd0, 1'b1);
    step_exp("neg_ovf",   1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 1'b1);

    // Back-to-back random stream with a one-cycle reset in the middle
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 3) rb = ~ra;
      step_ref("rand", 1'b0, ra, rb, i[0] ^ ($urandom_range(0, 3) == 0));
      if (i == 500) begin
        step_exp("mid_reset", 1'b1, $urandom, $urandom, 1'b1, 32'd0, 1'b0);
      end
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
